div_issue: RTL and testbench
============================

# div_issue

Issue/collect controller that sits between the execute stage and the 64-bit iterative divider, driving the divider's request side and consuming its result handshake. It accepts one RV64M divide/remainder op at a time, including the W variants. It formats operands (word sign/zero extension, signed flag), issues them to the divider and waits for the result. It then selects quotient or remainder, applies word sign extension and holds the value for writeback until accepted. Pipeline flush aborts the op and the in-flight division.

## Interface
Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- RD_W, 5, destination register tag width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; abort current op.
- op_valid  in  1  execute stage offers an op.
- op_ready  out  1  controller can accept; = (state==IDLE) & ~flush.
- op_func  in  2  bit0: 1 = unsigned (DIVU/REMU), bit1: 1 = remainder (REM/REMU).
- op_word  in  1  W-variant (32-bit operation, sign-extended result).
- op_rs1  in  XLEN  dividend source.
- op_rs2  in  XLEN  divisor source.
- op_rd  in  RD_W  destination tag.
- div_valid  out  1  request to divider, registered, one-cycle pulse.
- div_signed  out  1  signed division.
- dividend  out  XLEN  formatted dividend.
- divisor  out  XLEN  formatted divisor.
- div_flush  out  1  abort divider.
- quotient  in  XLEN  divider quotient.
- remainder  in  XLEN  divider remainder.
- div_o_valid  in  1  divider result valid.
- div_o_ready  out  1  controller accepts result.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback accepts.
- wb_rd  out  RD_W  destination tag.
- wb_data  out  XLEN  final result.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on op_valid & op_ready, latch the fields below and go to REQ.
  - div_signed = ~op_func[0].
  - rd, func[1], word.
  - Operands, word op: 32-bit low halves extended to 64 bits: sign-extend if signed, zero-extend if unsigned.
  - Operands, non-word op: passed unchanged.
- REQ: div_valid=1 for exactly this cycle; go to WAIT unconditionally.
- WAIT: div_o_ready=1. On div_o_valid & div_o_ready, go to RESP.
  - sel = func[1] ? remainder : quotient.
  - wb_data = word ? {{32{sel[31]}}, sel[31:0]} : sel.
  - wb_data and wb_rd are registered.
- RESP: wb_valid=1. wb_data and wb_rd are held stable until wb_valid & wb_ready, then go to IDLE.
- Divide-by-zero and signed overflow are handled entirely by the divider. No local special-casing. The results follow RISC-V because operands are pre-extended:
  - quotient all-ones, remainder = dividend.
  - -2^63 / -1 gives -2^63, remainder 0.
- dividend, divisor and div_signed stay stable from REQ through WAIT. The divider may reuse its cached result for identical operands, so a response may arrive the cycle after REQ.
- Flush, any state: go to IDLE next edge and deassert wb_valid, div_valid and div_o_ready.
  - div_flush is asserted (registered? no, combinational) only when flush & state∈{REQ,WAIT}.
  - In RESP the divider is already idle, so the result is simply discarded.
  - Flush has priority over op acceptance, the divider response and the wb handshake in the same cycle.

## Timing
- Reset values:
  - state=IDLE, op_ready=1 (if flush=0).
  - div_valid=0, div_signed=0, dividend=0, divisor=0, div_flush=0.
  - div_o_ready=0, wb_valid=0, wb_rd=0, wb_data=0.
- Latency:
  - Accept at edge T → div_valid high in cycle T+1.
  - Earliest div_o_valid is cycle T+2.
  - wb_valid rises the cycle after the divider handshake.
  - Normal division: about 66 divider cycles plus 3 controller cycles.
- Throughput: one op in flight. op_ready is low from REQ through RESP. A new op may be accepted in the cycle after the wb handshake.
- div_o_ready is never high outside WAIT, so a stray div_o_valid in other states is ignored.
- Reset mid-operation: immediate return to reset values. No div_flush is generated; the divider shares the reset.

## Test plan
- DIV, rs1=0xFFFF_FFFF_FFFF_FFF9 (-7), rs2=2 → div_signed=1, wb_data=0xFFFF_FFFF_FFFF_FFFD. REM on the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW, rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF → dividend=0xFFFF_FFFF_8000_0000, wb_data=0xFFFF_FFFF_8000_0000. DIVUW with rs1 low word 0xFFFF_FFFE, rs2=2 → dividend=0x0000_0000_FFFF_FFFE, wb_data=0x0000_0000_7FFF_FFFF.
- REMU, rs1=7, rs2=0 → wb_data=7. DIVU on the same operands → 0xFFFF_FFFF_FFFF_FFFF. In both cases wb_valid appears 2 cycles after div_valid.
- Hold wb_ready=0 for 5 cycles in RESP → wb_valid, wb_data and wb_rd stay stable, op_ready stays 0. After the handshake, op_ready=1 and back-to-back identical ops complete via the divider cache.
- Flush in WAIT, 10 cycles after div_valid → div_flush=1 for that cycle, next cycle IDLE with op_ready=1. A following DIV 100/7 returns 14 and no stale result.
- Flush in RESP simultaneous with wb_ready=1 → no writeback counted, state=IDLE. Flush simultaneous with op_valid in IDLE → op not accepted, div_valid stays 0.

Source files
------------

// File: rtl/div_issue_if.sv
// rtl/div_issue_if.sv - request, divider and writeback signal bundle for div_issue
interface div_issue_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  // execute-stage op offer
  logic            flush;
  logic            op_valid;
  logic            op_ready;
  logic [1:0]      op_func;
  logic            op_word;
  logic [XLEN-1:0] op_rs1;
  logic [XLEN-1:0] op_rs2;
  logic [RD_W-1:0] op_rd;
  // divider request / response
  logic            div_valid;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_flush;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;
  logic            div_o_valid;
  logic            div_o_ready;
  // writeback
  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  // controller side
  modport slave (
    input  flush, op_valid, op_func, op_word, op_rs1, op_rs2, op_rd,
    input  quotient, remainder, div_o_valid, wb_ready,
    output op_ready, div_valid, div_signed, dividend, divisor, div_flush,
    output div_o_ready, wb_valid, wb_rd, wb_data
  );

  // execute stage, divider and writeback side
  modport master (
    output flush, op_valid, op_func, op_word, op_rs1, op_rs2, op_rd,
    output quotient, remainder, div_o_valid, wb_ready,
    input  op_ready, div_valid, div_signed, dividend, divisor, div_flush,
    input  div_o_ready, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/div_issue.sv
// rtl/div_issue.sv - issue/collect controller for the 64-bit iterative divider
module div_issue #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input logic        clk,
  input logic        rst,
  div_issue_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            div_signed_q, div_signed_d;
  logic [XLEN-1:0] dividend_q, dividend_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic            rem_sel_q, rem_sel_d;
  logic            word_q, word_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] sel;

  // W-variant operand: low word extended by signedness
  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] x, input logic sgn);
    return {{(XLEN-32){sgn & x[31]}}, x[31:0]};
  endfunction

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      div_signed_q <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      rem_sel_q    <= 1'b0;
      word_q       <= 1'b0;
      rd_q         <= '0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      div_signed_q <= div_signed_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      rem_sel_q    <= rem_sel_d;
      word_q       <= word_d;
      rd_q         <= rd_d;
      wb_rd_q      <= wb_rd_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // next state: flush wins over every handshake in the same cycle
  always_comb begin
    state_d      = state_q;
    div_signed_d = div_signed_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    rem_sel_d    = rem_sel_q;
    word_d       = word_q;
    rd_d         = rd_q;
    wb_rd_d      = wb_rd_q;
    wb_data_d    = wb_data_q;
    sel          = rem_sel_q ? io.remainder : io.quotient;
    if (io.flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.op_valid) begin
            div_signed_d = ~io.op_func[0];
            rem_sel_d    = io.op_func[1];
            word_d       = io.op_word;
            rd_d         = io.op_rd;
            dividend_d   = io.op_word ? word_ext(io.op_rs1, ~io.op_func[0]) : io.op_rs1;
            divisor_d    = io.op_word ? word_ext(io.op_rs2, ~io.op_func[0]) : io.op_rs2;
            state_d      = REQ;
          end
        end
        REQ: state_d = WAIT;
        WAIT: begin
          if (io.div_o_valid) begin
            wb_data_d = word_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
            wb_rd_d   = rd_q;
            state_d   = RESP;
          end
        end
        RESP: begin
          if (io.wb_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // handshake outputs decoded from the registered state
  assign io.op_ready    = (state_q == IDLE) & ~io.flush;
  assign io.div_valid   = (state_q == REQ);
  assign io.div_flush   = io.flush & ((state_q == REQ) | (state_q == WAIT));
  assign io.div_o_ready = (state_q == WAIT) & ~io.flush;
  assign io.wb_valid    = (state_q == RESP);
  assign io.div_signed  = div_signed_q;
  assign io.dividend    = dividend_q;
  assign io.divisor     = divisor_q;
  assign io.wb_rd       = wb_rd_q;
  assign io.wb_data     = wb_data_q;

endmodule

// File: tb/tb_div_issue.sv
// tb/tb_div_issue.sv - directed self-checking bench for div_issue
module tb_div_issue;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  div_issue_if #(.XLEN(64), .RD_W(5)) bus ();
  div_issue #(.XLEN(64), .RD_W(5)) dut (.clk(clk), .rst(rst), .io(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic offer(input logic [1:0] f, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
    bus.op_valid = 1'b1; bus.op_func = f; bus.op_word = w;
    bus.op_rs1 = a; bus.op_rs2 = b; bus.op_rd = rd;
    step();
    bus.op_valid = 1'b0;
  endtask

  task automatic respond(input logic [63:0] q, input logic [63:0] r);
    bus.div_o_valid = 1'b1; bus.quotient = q; bus.remainder = r;
    step();
    bus.div_o_valid = 1'b0;
  endtask

  task automatic retire();
    bus.wb_ready = 1'b1;
    step();
    bus.wb_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks++; if ({bus.op_ready, bus.div_valid, bus.div_signed, bus.div_flush, bus.div_o_ready, bus.wb_valid} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 100000", {bus.op_ready, bus.div_valid, bus.div_signed, bus.div_flush, bus.div_o_ready, bus.wb_valid}); end
    checks++; if ({bus.dividend, bus.divisor, bus.wb_data, bus.wb_rd} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp 0", bus.dividend, bus.divisor, bus.wb_data, bus.wb_rd); end
    rst = 1'b0;
    step();
    // reset in the middle of an op
    offer(2'b00, 1'b0, 64'd100, 64'd7, 5'd1);
    step();
    checks++; if (bus.div_o_ready !== 1'b1) begin
      errors++; $display("FAIL pre_reset_wait div_o_ready got %b exp 1", bus.div_o_ready); end
    #1 rst = 1'b1;
    #1;
    checks++; if ({bus.op_ready, bus.div_o_ready, bus.div_flush} !== 3'b100 || bus.dividend !== 64'd0) begin
      errors++; $display("FAIL midop_reset got rdy=%b ordy=%b dfl=%b dvd=%h exp 1 0 0 0", bus.op_ready, bus.div_o_ready, bus.div_flush, bus.dividend); end
    step();
    rst = 1'b0;
    // a stray divider response in IDLE is ignored
    bus.div_o_valid = 1'b1; bus.quotient = 64'd5;
    #1;
    checks++; if (bus.div_o_ready !== 1'b0) begin
      errors++; $display("FAIL stray_ready got %b exp 0", bus.div_o_ready); end
    step();
    bus.div_o_valid = 1'b0;
    checks++; if (bus.wb_valid !== 1'b0 || bus.op_ready !== 1'b1) begin
      errors++; $display("FAIL stray_ignored got wbv=%b rdy=%b exp 0 1", bus.wb_valid, bus.op_ready); end
  endtask

  task automatic test_signed();
    offer(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
    checks++; if ({bus.div_valid, bus.div_signed, bus.op_ready} !== 3'b110) begin
      errors++; $display("FAIL div_req got %b exp 110", {bus.div_valid, bus.div_signed, bus.op_ready}); end
    checks++; if (bus.dividend !== 64'hFFFF_FFFF_FFFF_FFF9 || bus.divisor !== 64'd2) begin
      errors++; $display("FAIL div_operands got %h %h exp fffffffffffffff9 2", bus.dividend, bus.divisor); end
    step();
    checks++; if ({bus.div_valid, bus.div_o_ready} !== 2'b01) begin
      errors++; $display("FAIL div_wait got %b exp 01", {bus.div_valid, bus.div_o_ready}); end
    respond(64'hFFFF_FFFF_FFFF_FFFD, ONES);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 64'hFFFF_FFFF_FFFF_FFFD || bus.wb_rd !== 5'd3) begin
      errors++; $display("FAIL div_result got v=%b %h rd=%0d exp 1 fffffffffffffffd 3", bus.wb_valid, bus.wb_data, bus.wb_rd); end
    retire();
    offer(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4);
    step();
    respond(64'hFFFF_FFFF_FFFF_FFFD, ONES);
    checks++; if (bus.wb_data !== ONES || bus.wb_rd !== 5'd4) begin
      errors++; $display("FAIL rem_result got %h rd=%0d exp ffffffffffffffff 4", bus.wb_data, bus.wb_rd); end
    retire();
    // signed overflow passes through unchanged
    offer(2'b00, 1'b0, 64'h8000_0000_0000_0000, ONES, 5'd5);
    step();
    respond(64'h8000_0000_0000_0000, 64'd0);
    checks++; if (bus.wb_data !== 64'h8000_0000_0000_0000) begin
      errors++; $display("FAIL overflow_result got %h exp 8000000000000000", bus.wb_data); end
    retire();
  endtask

  task automatic test_word();
    offer(2'b00, 1'b1, 64'h0000_0000_8000_0000, ONES, 5'd7);
    checks++; if (bus.dividend !== 64'hFFFF_FFFF_8000_0000 || bus.divisor !== ONES || bus.div_signed !== 1'b1) begin
      errors++; $display("FAIL divw_operands got %h %h s=%b exp ffffffff80000000 ffffffffffffffff 1", bus.dividend, bus.divisor, bus.div_signed); end
    step();
    respond(64'h0000_0000_8000_0000, 64'd0);
    checks++; if (bus.wb_data !== 64'hFFFF_FFFF_8000_0000) begin
      errors++; $display("FAIL divw_result got %h exp ffffffff80000000", bus.wb_data); end
    retire();
    offer(2'b01, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'hABCD_0000_0000_0002, 5'd8);
    checks++; if (bus.dividend !== 64'h0000_0000_FFFF_FFFE || bus.divisor !== 64'd2 || bus.div_signed !== 1'b0) begin
      errors++; $display("FAIL divuw_operands got %h %h s=%b exp 00000000fffffffe 2 0", bus.dividend, bus.divisor, bus.div_signed); end
    step();
    respond(64'h0000_0000_7FFF_FFFF, 64'd0);
    checks++; if (bus.wb_data !== 64'h0000_0000_7FFF_FFFF) begin
      errors++; $display("FAIL divuw_result got %h exp 000000007fffffff", bus.wb_data); end
    retire();
  endtask

  task automatic test_div_by_zero();
    offer(2'b11, 1'b0, 64'd7, 64'd0, 5'd9);
    checks++; if (bus.div_valid !== 1'b1) begin
      errors++; $display("FAIL remu0_req got %b exp 1", bus.div_valid); end
    step();
    checks++; if (bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL remu0_early got %b exp 0", bus.wb_valid); end
    respond(ONES, 64'd7);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 64'd7) begin
      errors++; $display("FAIL remu0_result got v=%b %h exp 1 7", bus.wb_valid, bus.wb_data); end
    retire();
    offer(2'b01, 1'b0, 64'd7, 64'd0, 5'd10);
    step();
    respond(ONES, 64'd7);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== ONES) begin
      errors++; $display("FAIL divu0_result got v=%b %h exp 1 ffffffffffffffff", bus.wb_valid, bus.wb_data); end
    retire();
  endtask

  task automatic test_backpressure();
    offer(2'b00, 1'b0, 64'd100, 64'd7, 5'd11);
    step();
    respond(64'd14, 64'd2);
    for (int i = 0; i < 5; i++) begin
      bus.quotient = 64'd99; bus.remainder = 64'd99;
      checks++; if ({bus.wb_valid, bus.op_ready} !== 2'b10 || bus.wb_data !== 64'd14 || bus.wb_rd !== 5'd11) begin
        errors++; $display("FAIL hold_%0d got v=%b rdy=%b %h rd=%0d exp 1 0 14 11", i, bus.wb_valid, bus.op_ready, bus.wb_data, bus.wb_rd); end
      step();
    end
    retire();
    checks++; if (bus.op_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      errors++; $display("FAIL after_wb got rdy=%b v=%b exp 1 0", bus.op_ready, bus.wb_valid); end
    offer(2'b00, 1'b0, 64'd100, 64'd7, 5'd12);
    checks++; if (bus.div_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_req got %b exp 1", bus.div_valid); end
    step();
    respond(64'd14, 64'd2);
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 64'd14 || bus.wb_rd !== 5'd12) begin
      errors++; $display("FAIL b2b_result got v=%b %h rd=%0d exp 1 14 12", bus.wb_valid, bus.wb_data, bus.wb_rd); end
    retire();
  endtask

  task automatic test_flush_wait();
    offer(2'b00, 1'b0, 64'd100, 64'd7, 5'd13);
    for (int i = 0; i < 10; i++) step();
    bus.flush = 1'b1;
    #1;
    checks++; if ({bus.div_flush, bus.op_ready} !== 2'b10) begin
      errors++; $display("FAIL flush_wait got dfl=%b rdy=%b exp 1 0", bus.div_flush, bus.op_ready); end
    step();
    bus.flush = 1'b0;
    #1;
    checks++; if ({bus.op_ready, bus.div_valid, bus.div_o_ready, bus.div_flush} !== 4'b1000) begin
      errors++; $display("FAIL flush_idle got %b exp 1000", {bus.op_ready, bus.div_valid, bus.div_o_ready, bus.div_flush}); end
    offer(2'b00, 1'b0, 64'd100, 64'd7, 5'd14);
    step();
    respond(64'd14, 64'd2);
    checks++; if (bus.wb_data !== 64'd14 || bus.wb_rd !== 5'd14) begin
      errors++; $display("FAIL after_flush got %h rd=%0d exp 14 14", bus.wb_data, bus.wb_rd); end
    retire();
  endtask

  task automatic test_flush_resp_idle();
    offer(2'b10, 1'b0, 64'd100, 64'd7, 5'd15);
    step();
    respond(64'd14, 64'd2);
    bus.flush = 1'b1; bus.wb_ready = 1'b1;
    #1;
    checks++; if (bus.div_flush !== 1'b0) begin
      errors++; $display("FAIL flush_resp_dfl got %b exp 0", bus.div_flush); end
    step();
    bus.flush = 1'b0; bus.wb_ready = 1'b0;
    #1;
    checks++; if ({bus.wb_valid, bus.op_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_resp got v=%b rdy=%b exp 0 1", bus.wb_valid, bus.op_ready); end
    // flush together with an op offer: op is dropped
    bus.flush = 1'b1;
    bus.op_valid = 1'b1; bus.op_func = 2'b00; bus.op_word = 1'b0;
    bus.op_rs1 = 64'd50; bus.op_rs2 = 64'd5; bus.op_rd = 5'd16;
    #1;
    checks++; if ({bus.op_ready, bus.div_flush} !== 2'b00) begin
      errors++; $display("FAIL flush_offer got rdy=%b dfl=%b exp 0 0", bus.op_ready, bus.div_flush); end
    step();
    bus.flush = 1'b0; bus.op_valid = 1'b0;
    #1;
    checks++; if ({bus.div_valid, bus.op_ready} !== 2'b01) begin
      errors++; $display("FAIL flush_offer_drop got dv=%b rdy=%b exp 0 1", bus.div_valid, bus.op_ready); end
    step();
    checks++; if ({bus.div_valid, bus.div_o_ready, bus.wb_valid} !== 3'b000) begin
      errors++; $display("FAIL flush_offer_quiet got %b exp 000", {bus.div_valid, bus.div_o_ready, bus.wb_valid}); end
  endtask

  initial begin
    bus.flush = 1'b0; bus.op_valid = 1'b0; bus.op_func = 2'b00; bus.op_word = 1'b0;
    bus.op_rs1 = '0; bus.op_rs2 = '0; bus.op_rd = '0;
    bus.quotient = '0; bus.remainder = '0; bus.div_o_valid = 1'b0; bus.wb_ready = 1'b0;
    test_reset();
    test_signed();
    test_word();
    test_div_by_zero();
    test_backpressure();
    test_flush_wait();
    test_flush_resp_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
